// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Brief    : Shared channel-index type and round-robin helper for rr_arbiter_4to1.
// Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] ch_idx_t;

    // Relies on 2-bit overflow so channel 3 wraps back to channel 0.
    function automatic ch_idx_t rr_next(input ch_idx_t idx);
        return idx + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_4to1.sv
`default_nettype none
// ============================================================================
// Module   : mux_4to1
// Brief    : Library 4:1 bus multiplexer, sel=0 picks in_a ... sel=3 picks in_d.
// Revision : 1.0 - initial release
// ============================================================================
module mux_4to1 #(
    parameter int BUS_WIDTH = 4
) (
    input  logic [BUS_WIDTH-1:0] in_a,
    input  logic [BUS_WIDTH-1:0] in_b,
    input  logic [BUS_WIDTH-1:0] in_c,
    input  logic [BUS_WIDTH-1:0] in_d,
    input  logic [1:0]           sel,
    output logic [BUS_WIDTH-1:0] out
);

    always_comb begin
        out = in_a;
        case (sel)
            2'd0:    out = in_a;
            2'd1:    out = in_b;
            2'd2:    out = in_c;
            default: out = in_d;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rr_priority_enc.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_enc
// Brief    : Rotating priority encoder; first set req bit at or after ptr wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_enc
    import arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  ch_idx_t           ptr,
    output ch_idx_t           winner,
    output logic              any
);

    ch_idx_t v_idx;
    logic    v_found;

    // With no request the winner falls back to ptr so the select is stable.
    always_comb begin
        winner  = ptr;
        any     = |req;
        v_idx   = ptr;
        v_found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            v_idx = ptr + ch_idx_t'(k);
            if (!v_found && req[v_idx]) begin
                winner  = v_idx;
                v_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_4to1.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_4to1
// Brief    : 4-channel round-robin arbiter with registered output stage.
//            Optional packet locking enabled by macro RR_ARBITER_PKT_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_4to1
    import arb_pkg::*;
#(
    parameter int BUS_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    in_valid,
`ifdef RR_ARBITER_PKT_LOCK_EN
    input  logic [NUM_CH-1:0]    in_last,
`endif
    input  logic [BUS_WIDTH-1:0] in_data_a,
    input  logic [BUS_WIDTH-1:0] in_data_b,
    input  logic [BUS_WIDTH-1:0] in_data_c,
    input  logic [BUS_WIDTH-1:0] in_data_d,
    output logic [NUM_CH-1:0]    in_ready,
    output ch_idx_t              arb_sel,
    output logic                 out_valid,
    output logic [BUS_WIDTH-1:0] out_data,
    output ch_idx_t              out_src,
    input  logic                 out_ready
);

    logic                 r_out_valid;
    logic [BUS_WIDTH-1:0] r_out_data;
    ch_idx_t              r_out_src;
    ch_idx_t              r_ptr;

    logic [NUM_CH-1:0]    w_req;
    ch_idx_t              w_winner;
    logic                 w_any;
    logic                 w_load;
    logic                 w_accept;
    ch_idx_t              w_ptr_nxt;
    logic [BUS_WIDTH-1:0] w_mux;

`ifdef RR_ARBITER_PKT_LOCK_EN
    logic    r_locked;
    ch_idx_t r_lock_ch;

    // While locked only the owning channel may win; if it drops valid, nobody does.
    assign w_req     = r_locked ? (in_valid & (4'b0001 << r_lock_ch)) : in_valid;
    assign w_ptr_nxt = in_last[w_winner] ? rr_next(w_winner) : r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked  <= 1'b0;
            r_lock_ch <= '0;
        end else if (w_accept) begin
            r_locked  <= !in_last[w_winner];
            r_lock_ch <= w_winner;
        end
    end
`else
    assign w_req     = in_valid;
    assign w_ptr_nxt = rr_next(w_winner);
`endif

    rr_priority_enc u_enc (
        .req    (w_req),
        .ptr    (r_ptr),
        .winner (w_winner),
        .any    (w_any)
    );

    mux_4to1 #(.BUS_WIDTH(BUS_WIDTH)) u_mux (
        .in_a (in_data_a),
        .in_b (in_data_b),
        .in_c (in_data_c),
        .in_d (in_data_d),
        .sel  (arb_sel),
        .out  (w_mux)
    );

    // rst_n gates the accept so no channel sees ready while reset is held.
    assign w_load   = !r_out_valid || out_ready;
    assign w_accept = w_load && w_any && rst_n;
    assign in_ready = w_accept ? (4'b0001 << w_winner) : 4'b0000;
    assign arb_sel  = w_winner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_ptr       <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux;
            r_out_src   <= w_winner;
            r_ptr       <= w_ptr_nxt;
        end else if (w_load) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_4to1.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter_4to1
// Brief    : Self-checking scoreboard bench for rr_arbiter_4to1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_4to1;

    localparam int BW = 4;

    typedef struct {
        logic [1:0]    src;
        logic [BW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    in_valid;
    logic [3:0]    in_last;
    logic [BW-1:0] in_data_a, in_data_b, in_data_c, in_data_d;
    logic [3:0]    in_ready;
    logic [1:0]    arb_sel;
    logic          out_valid;
    logic [BW-1:0] out_data;
    logic [1:0]    out_src;
    logic          out_ready;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t e;

    // Reference model state
    logic [1:0]    m_ptr;
    logic          m_ov;
    logic [BW-1:0] m_data;
    logic [1:0]    m_src;
    logic          m_lock;
    logic [1:0]    m_lch;
    logic          m_new;
    logic [3:0]    e_ready;
    logic [1:0]    e_win;
    logic          e_acc;
    logic          e_load;

    always #5 clk = ~clk;

    rr_arbiter_4to1 #(.BUS_WIDTH(BW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
`ifdef RR_ARBITER_PKT_LOCK_EN
        .in_last   (in_last),
`endif
        .in_data_a (in_data_a),
        .in_data_b (in_data_b),
        .in_data_c (in_data_c),
        .in_data_d (in_data_d),
        .in_ready  (in_ready),
        .arb_sel   (arb_sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    function automatic logic [BW-1:0] data_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return in_data_a;
            2'd1:    return in_data_b;
            2'd2:    return in_data_c;
            default: return in_data_d;
        endcase
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_ov = 0; m_data = 0; m_src = 0; m_lock = 0; m_lch = 0; m_new = 0;
        sb.delete();
    endtask

    task automatic model_comb();
        logic [3:0] req;
        logic [1:0] idx;
        logic       found;
        req    = m_lock ? (in_valid & (4'b0001 << m_lch)) : in_valid;
        e_load = !m_ov || out_ready;
        e_win  = m_ptr;
        found  = 0;
        for (int k = 0; k < 4; k++) begin
            idx = 2'((int'(m_ptr) + k) % 4);
            if (!found && req[idx]) begin
                e_win = idx;
                found = 1;
            end
        end
        e_acc   = e_load && found;
        e_ready = e_acc ? (4'b0001 << e_win) : 4'b0000;
    endtask

    task automatic tick();
        model_comb();
        @(posedge clk);
        #1;
        m_new = e_acc;
        if (e_acc) begin
            m_ov   = 1;
            m_src  = e_win;
            m_data = data_of(e_win);
`ifdef RR_ARBITER_PKT_LOCK_EN
            if (in_last[e_win]) begin
                m_ptr  = e_win + 2'd1;
                m_lock = 0;
            end else begin
                m_lock = 1;
                m_lch  = e_win;
            end
`else
            m_ptr = e_win + 2'd1;
`endif
        end else if (e_load) begin
            m_ov = 0;
        end
    endtask

    task automatic set_data(input int a, input int b, input int c, input int d);
        in_data_a = BW'(a); in_data_b = BW'(b); in_data_c = BW'(c); in_data_d = BW'(d);
    endtask

    task automatic test_reset();
        rst_n = 0; in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1;
        set_data(1, 2, 3, 4);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
        n_cmp++; if (out_src !== 2'd0) begin n_fail++; $display("FAIL reset_out_src got=%0d want=0", out_src); end
        n_cmp++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready got=%b want=0000", in_ready); end
        rst_n = 1;
        #1;
        n_cmp++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL post_reset_in_ready got=%b want=0001", in_ready); end
    endtask

    task automatic test_rotation();
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (in_ready !== (4'b0001 << (k % 4))) begin
                n_fail++; $display("FAIL rot_in_ready[%0d] got=%b", k, in_ready);
            end
            sb.push_back('{src: 2'(k % 4), data: BW'(k % 4 + 1)});
            tick();
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rot_out_valid[%0d] got=%b want=1", k, out_valid); end
            e = sb.pop_front();
            n_cmp++;
            if (out_src !== e.src || out_data !== e.data) begin
                n_fail++; $display("FAIL rot_out[%0d] got src=%0d data=%0d want src=%0d data=%0d", k, out_src, out_data, e.src, e.data);
            end
        end
    endtask

    task automatic test_wrap();
        in_valid = 4'b0100;
        sb.push_back('{src: 2'd2, data: BW'(3)});
        tick();
        e = sb.pop_front();
        n_cmp++; if (out_src !== e.src) begin n_fail++; $display("FAIL wrap_ch2 got=%0d want=%0d", out_src, e.src); end
        in_valid = 4'b0101;
        #1;
        n_cmp++; if (arb_sel !== 2'd0 || in_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_grant got sel=%0d ready=%b want sel=0 ready=0001", arb_sel, in_ready); end
        sb.push_back('{src: 2'd0, data: BW'(1)});
        tick();
        e = sb.pop_front();
        n_cmp++; if (out_src !== e.src || out_data !== e.data) begin n_fail++; $display("FAIL wrap_out got src=%0d data=%0d want src=%0d data=%0d", out_src, out_data, e.src, e.data); end
        in_valid = 4'b0000;
        #1;
        n_cmp++; if (arb_sel !== 2'd1) begin n_fail++; $display("FAIL wrap_ptr got=%0d want=1", arb_sel); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_out_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_backpressure();
        in_valid = 4'b0001;
        sb.push_back('{src: 2'd0, data: BW'(1)});
        tick();
        e = sb.pop_front();
        out_ready = 0; in_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%b want=0000", k, in_ready); end
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_src !== e.src || out_data !== e.data) begin
                n_fail++; $display("FAIL bp_hold[%0d] got v=%b src=%0d data=%0d want v=1 src=%0d data=%0d", k, out_valid, out_src, out_data, e.src, e.data);
            end
        end
        out_ready = 1;
        #1;
        n_cmp++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ready got=%b want=0010", in_ready); end
        sb.push_back('{src: 2'd1, data: BW'(2)});
        tick();
        e = sb.pop_front();
        n_cmp++; if (out_src !== e.src || out_data !== e.data) begin n_fail++; $display("FAIL bp_release_out got src=%0d data=%0d want src=%0d data=%0d", out_src, out_data, e.src, e.data); end
    endtask

    task automatic test_single_req();
        in_valid = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL single_ready[%0d] got=%b want=1000", k, in_ready); end
            sb.push_back('{src: 2'd3, data: BW'(4)});
            tick();
            e = sb.pop_front();
            n_cmp++; if (out_src !== e.src || out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out[%0d] got src=%0d v=%b want src=3 v=1", k, out_src, out_valid); end
        end
        in_valid = 4'b0000;
        #1;
        n_cmp++; if (arb_sel !== 2'd0) begin n_fail++; $display("FAIL single_ptr got=%0d want=0", arb_sel); end
        tick();
    endtask

    task automatic test_reset_midflight();
        out_ready = 0; in_valid = 4'b0100;
        tick();
        #2 rst_n = 0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL midreset got v=%b data=%0d want v=0 data=0", out_valid, out_data); end
        @(posedge clk);
        #1 rst_n = 1;
        model_reset();
        out_ready = 1; in_valid = 4'b0000;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_replay got v=%b want=0", out_valid); end
    endtask

`ifdef RR_ARBITER_PKT_LOCK_EN
    task automatic test_pkt_lock();
        int want_src[5] = '{1, 1, 1, 2, 0};
        in_last = 4'b1111; in_valid = 4'b0001;
        tick();
        in_valid = 4'b0111;
        for (int k = 0; k < 5; k++) begin
            in_last = (k < 2) ? 4'b0000 : 4'b1111;
            if (k == 3) in_valid = 4'b0101;
            sb.push_back('{src: 2'(want_src[k]), data: BW'(want_src[k] + 1)});
            tick();
            e = sb.pop_front();
            n_cmp++; if (out_src !== e.src || out_data !== e.data) begin n_fail++; $display("FAIL lock_seq[%0d] got src=%0d want src=%0d", k, out_src, e.src); end
        end
        in_valid = 4'b0010; in_last = 4'b0000;
        tick();
        in_valid = 4'b0101;
        #1;
        n_cmp++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL lock_stall got=%b want=0000", in_ready); end
        tick();
        in_valid = 4'b0010; in_last = 4'b1111;
        #1;
        n_cmp++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL lock_resume got=%b want=0010", in_ready); end
        tick();
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            in_valid  = 4'($urandom);
            in_last   = 4'($urandom);
            out_ready = ($urandom % 4) != 0;
            set_data(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
            #1;
            model_comb();
            n_cmp++;
            if (in_ready !== e_ready || arb_sel !== e_win) begin
                n_fail++; $display("FAIL rand_comb[%0d] got ready=%b sel=%0d want ready=%b sel=%0d", k, in_ready, arb_sel, e_ready, e_win);
            end
            if (e_acc) sb.push_back('{src: e_win, data: data_of(e_win)});
            tick();
            n_cmp++; if (out_valid !== m_ov) begin n_fail++; $display("FAIL rand_valid[%0d] got=%b want=%b", k, out_valid, m_ov); end
            if (m_new) begin
                e = sb.pop_front();
                n_cmp++;
                if (out_src !== e.src || out_data !== e.data) begin
                    n_fail++; $display("FAIL rand_out[%0d] got src=%0d data=%0d want src=%0d data=%0d", k, out_src, out_data, e.src, e.data);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_wrap();
        test_backpressure();
        test_single_req();
`ifdef RR_ARBITER_PKT_LOCK_EN
        test_pkt_lock();
`endif
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
